// File: rtl/piso_serializer.sv
// piso_serializer
// Parallel-in/serial-out shifter with a valid/ready load handshake, a
// shift-enable stall input and registered valid/last framing on the serial
// side. Consecutive words stream without a gap when the producer offers the
// next word on the edge that retires the last bit of the current one.

module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pi_valid,
  output logic             pi_ready,
  input  logic [WIDTH-1:0] pi_data,
  input  logic             shift_en,
  output logic             so,
  output logic             so_valid,
  output logic             so_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             so_q, so_d;
  logic             so_valid_q, so_valid_d;
  logic             so_last_q, so_last_d;
  logic             load_en;
  logic             out_bit;

  // A word is taken only when the handshake completes; a stalled last bit
  // keeps pi_ready low so the producer's word is never captured early.
  assign pi_ready = (state_q == ST_IDLE) || (so_last_q && shift_en);
  assign load_en  = pi_valid && pi_ready;
  assign busy     = (state_q == ST_SHIFT);
  assign so       = so_q;
  assign so_valid = so_valid_q;
  assign so_last  = so_last_q;

  // Next state of the FSM, shift register and bit counter.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          shreg_d = pi_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          if (cnt_q == CNT_MAX) begin
            if (load_en) begin
              shreg_d = pi_data;
              cnt_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Serial-side outputs are precomputed from the next state so they are
  // plain flops; leaving SHIFT forces them low whatever the register holds.
  always_comb begin
    out_bit    = LSB_FIRST ? shreg_d[0] : shreg_d[WIDTH-1];
    so_valid_d = (state_d == ST_SHIFT);
    so_d       = so_valid_d && out_bit;
    so_last_d  = so_valid_d && (cnt_d == CNT_MAX);
  end

  // State registers; reset aborts any word in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      so_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      so_q       <= so_d;
      so_valid_q <= so_valid_d;
      so_last_q  <= so_last_d;
    end
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer. It is the successor to the fixed 4-bit PISO and adds configurable width, selectable bit order, a valid/ready load handshake and a shift-enable stall input. It also adds serial-side valid/last framing and gapless back-to-back word streaming. It sits between a word-oriented producer and a bit-serial link or downstream shifter.

## Interface
- WIDTH, 8, word width in bits; legal values are WIDTH >= 2.
- LSB_FIRST, 0, bit order: 0 sends pi_data[WIDTH-1] first, 1 sends pi_data[0] first.

- clk  input  1  single clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pi_valid  input  1  producer has a word on pi_data.
- pi_ready  output  1  serializer accepts a word this cycle; a load occurs on a rising edge with pi_valid && pi_ready.
- pi_data  input  WIDTH  parallel word, sampled only on a load edge.
- shift_en  input  1  advances to the next bit on a rising edge while a word is being sent; 0 stalls.
- so  output  1  current serial bit; registered.
- so_valid  output  1  so carries a valid data bit; registered.
- so_last  output  1  so carries the final bit of the word; registered.
- busy  output  1  a word is in flight (state SHIFT).

## Operation
- The block has two states, IDLE and SHIFT. It holds a WIDTH-bit shift register and a bit counter `cnt` of width $clog2(WIDTH) that runs 0..WIDTH-1.
- IDLE:
  - pi_ready = 1, so = 0, so_valid = 0, so_last = 0, busy = 0.
  - On an edge with pi_valid = 1: load the shift register from pi_data, set cnt = 0, go to SHIFT.
- SHIFT:
  - so_valid = 1, busy = 1.
  - so = MSB of the shift register when LSB_FIRST = 0, LSB when LSB_FIRST = 1.
  - so_last = (cnt == WIDTH-1).
- Edge in SHIFT with shift_en = 0: nothing changes, so everything holds, including so.
- Edge in SHIFT with shift_en = 1 and so_last = 0: shift the register toward the output end (zero fill) and increment cnt.
- Edge in SHIFT with shift_en = 1 and so_last = 1, the word is complete:
  - If pi_valid = 1: load the new word, set cnt = 0, stay in SHIFT. This is the gapless case.
  - Otherwise: go to IDLE.
- pi_ready = (state == IDLE) || (so_last && shift_en). This is combinational from registered state and shift_en; there is no combinational path from pi_valid.
- pi_valid while pi_ready = 0 is ignored. The producer must hold the word until it is accepted; pi_data is not captured early.
- Entering IDLE forces the serial-side outputs to 0 regardless of shift register contents.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE, shift register = 0, cnt = 0.
  - so = 0, so_valid = 0, so_last = 0, busy = 0.
  - pi_ready = 1 once rst_n is high; no load is possible while rst_n is low.
- Reset mid-word aborts the word immediately. The remaining bits are discarded and are never resumed.
- Latency: the first bit appears on so, with so_valid = 1, in the cycle after the load edge.
- With shift_en held at 1, a word takes exactly WIDTH consecutive cycles of so_valid. so_last is high only in the WIDTH-th cycle.
- Back-to-back words with shift_en = 1 and pi_valid = 1 at each last-bit edge produce N*WIDTH consecutive so_valid cycles, with no idle bubble.
- Stall: shift_en low for k cycles stretches the current bit by k cycles. The word length is WIDTH + total stall cycles.
- Stall on the last bit: so_last stays high and pi_ready stays 0 until shift_en returns to 1.

## Test plan
- WIDTH=4, LSB_FIRST=0, load 4'b1011 with shift_en=1 -> so = 1,0,1,1 on the 4 cycles after the load edge; so_last only on the 4th; then so_valid=0 and pi_ready=1.
- WIDTH=8, LSB_FIRST=1, load 8'hA5 -> so = 1,0,1,0,0,1,0,1. Repeat with LSB_FIRST=0 -> so = 1,0,1,0,0,1,0,1 reversed order, i.e. the MSB-first sequence 1,0,1,0,0,1,0,1 of 8'hA5 equals its own bit pattern read from bit 7; check against pi_data[7:0] directly.
- WIDTH=4, word 4'b1100, shift_en low for 3 cycles after the 2nd bit -> so holds 1 for 3 extra cycles and the word spans 7 so_valid cycles with the bit order unchanged.
- WIDTH=4, words 4'b1001 then 4'b0110 with pi_valid held high -> 8 consecutive so_valid cycles, so = 1,0,0,1,0,1,1,0, so_last on cycles 4 and 8, pi_ready pulses exactly on the two last-bit edges.
- pi_valid asserted with 4'b1111 during bit 2 of 4'b0000 -> ignored (pi_ready=0); the current word completes, then 1111 is loaded at the last-bit edge.
- rst_n pulsed low asynchronously during bit 3 of 8'hFF -> so, so_valid, so_last and busy go to 0 without waiting for clk; after release pi_ready=1 and a new load of 8'h81 serializes correctly.
